// File: rtl/ftdi_to_fifo_wr_ctrl.sv
// FTDI synchronous 245 FIFO receive controller: pulls bytes over RXF#/OE#/RD# into the RX FIFO.
// Optional statistics (rx_byte_cnt, rx_drop) are built when FTDI_RX_STAT_EN is defined.
module ftdi_to_fifo_wr_ctrl #(
  parameter int FIFO_DEPTH = 2048,
  parameter int HEADROOM   = 8,
  parameter int MAX_BURST  = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ftdi_rxf_n,
  input  logic [7:0]  ftdi_data,
  output logic        ftdi_oe_n,
  output logic        ftdi_rd_n,
  input  logic        tx_busy,
  input  logic [10:0] fifo_usedw,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        rx_active,
`ifdef FTDI_RX_STAT_EN
  output logic [31:0] rx_byte_cnt,
  output logic        rx_drop,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [11:0] HIGH_WATER = 12'(FIFO_DEPTH - HEADROOM);
  localparam logic [10:0] BURST_LAST = 11'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OE      = 2'd1,
    READ    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] burst_cnt;
  logic [10:0] burst_inc;
  logic        room;
  logic        capture;
  logic        burst_done;
  logic        oe_n_next;
  logic        rd_n_next;
  logic        active_next;

  // A byte is on the bus whenever RD# is asserted (READ) and RXF# is low at the edge.
  assign room       = ({1'b0, fifo_usedw} < HIGH_WATER) && !fifo_full;
  assign capture    = (state == READ) && !ftdi_rxf_n;
  assign burst_inc  = burst_cnt + 11'd1;
  assign burst_done = capture && (burst_inc == BURST_LAST);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!ftdi_rxf_n && room && !tx_busy) state_next = OE;
      OE:      state_next = ftdi_rxf_n ? RELEASE : READ;
      READ:    if (ftdi_rxf_n || !room || burst_done) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they change together with the state register.
  always_comb begin
    oe_n_next   = 1'b1;
    rd_n_next   = 1'b1;
    active_next = 1'b0;
    case (state_next)
      OE:      begin oe_n_next = 1'b0; active_next = 1'b1; end
      READ:    begin oe_n_next = 1'b0; rd_n_next = 1'b0; active_next = 1'b1; end
      RELEASE: active_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftdi_oe_n  <= 1'b1;
      ftdi_rd_n  <= 1'b1;
      rx_active  <= 1'b0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= 8'h00;
      burst_cnt  <= 11'd0;
    end else begin
      ftdi_oe_n  <= oe_n_next;
      ftdi_rd_n  <= rd_n_next;
      rx_active  <= active_next;
      fifo_wrreq <= capture && !fifo_full;
      if (capture) fifo_data <= ftdi_data;
      if (state == OE)  burst_cnt <= 11'd0;
      else if (capture) burst_cnt <= burst_inc;
    end
  end

`ifdef FTDI_RX_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_cnt <= 32'd0;
      rx_drop     <= 1'b0;
    end else begin
      if (fifo_wrreq)             rx_byte_cnt <= rx_byte_cnt + 32'd1;
      if (capture && fifo_full)   rx_drop     <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ftdi_to_fifo_wr_ctrl.sv
// Bench for ftdi_to_fifo_wr_ctrl: FTDI byte-source model, write scoreboard, directed scenarios.
module tb_ftdi_to_fifo_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ftdi_rxf_n = 1'b1;
  logic [7:0]  ftdi_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic [10:0] fifo_usedw = 11'd0;
  logic        fifo_full = 1'b0;
  logic        ftdi_oe_n;
  logic        ftdi_rd_n;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;
  logic        rx_active;
  logic [1:0]  dbg_state;
`ifdef FTDI_RX_STAT_EN
  logic [31:0] rx_byte_cnt;
  logic        rx_drop;
`endif

  ftdi_to_fifo_wr_ctrl #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .ftdi_rxf_n(ftdi_rxf_n), .ftdi_data(ftdi_data),
    .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .tx_busy(tx_busy),
    .fifo_usedw(fifo_usedw), .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .rx_active(rx_active),
`ifdef FTDI_RX_STAT_EN
    .rx_byte_cnt(rx_byte_cnt), .rx_drop(rx_drop),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ftdi_q[$];
  int         pops = 0;
  int         pops_at_oe = 0;
  int         burst_log[$];
  logic       pop_now;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // FTDI model: a byte leaves the chip at each edge with RD# and RXF# both low.
  always @(posedge clk or negedge clk) begin
    pop_now = clk && rst_n && !ftdi_rd_n && !ftdi_rxf_n;
    #1;
    if (pop_now && ftdi_q.size() > 0) begin
      void'(ftdi_q.pop_front());
      pops++;
    end
    if (ftdi_q.size() > 0) begin
      ftdi_rxf_n = 1'b0;
      ftdi_data  = ftdi_q[0];
    end else begin
      ftdi_rxf_n = 1'b1;
      ftdi_data  = 8'h00;
    end
  end

  // scoreboard monitor and burst-length logger
  always @(negedge clk) begin
    if (fifo_wrreq) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected got=%0h want=none", fifo_data);
      end else begin
        check("wr_data", {24'd0, fifo_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (dbg_state == 2'd1) pops_at_oe = pops;
    if (dbg_state == 2'd3) begin
      check("release_pins", {30'd0, ftdi_oe_n, ftdi_rd_n}, 32'd3);
      burst_log.push_back(pops - pops_at_oe);
    end
  end

  task automatic load(input logic [7:0] first, input int n, input bit expect_wr);
    for (int i = 0; i < n; i++) begin
      ftdi_q.push_back(first + 8'(i));
      if (expect_wr) exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(ftdi_q.size() == 0 && dbg_state == 2'd0 && !fifo_wrreq) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, {31'd0, (n < 200)}, 32'd1);
    check({name, "_exp_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (ftdi_rd_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_read_entered"}, {31'd0, !ftdi_rd_n}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] t1 [7];
    int base;
    int p0;
    t1 = '{6'b010110, 6'b100010, 6'b100011, 6'b100011, 6'b100011, 6'b111111, 6'b001100};

    repeat (3) @(negedge clk);
    check("rst_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    check("rst_rd_n", {31'd0, ftdi_rd_n}, 32'd1);
    check("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    check("rst_data", {24'd0, fifo_data}, 32'd0);
    check("rst_active", {31'd0, rx_active}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // four bytes: cycle-exact pin and state sequence
    load(8'hA1, 4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("seq4_cyc%0d", i),
            {26'd0, dbg_state, ftdi_oe_n, ftdi_rd_n, rx_active, fifo_wrreq}, {26'd0, t1[i]});
    end
    wait_drain("seq4");

    // three bytes: READ ends because RXF# rises
    load(8'hB1, 3, 1'b1);
    wait_drain("rxf_exit");
    check("rxf_exit_burst", burst_log[burst_log.size()-1], 32'd3);

    // ten bytes with a four-byte burst limit
    base = burst_log.size();
    load(8'hC0, 10, 1'b1);
    wait_drain("burst10");
    check("burst10_count", burst_log.size() - base, 32'd3);
    check("burst10_b0", burst_log[base], 32'd4);
    check("burst10_b1", burst_log[base+1], 32'd4);
    check("burst10_b2", burst_log[base+2], 32'd2);

    // watermark: fill level reaches the high-water mark during the burst
    fifo_usedw = 11'd2039;
    p0 = pops;
    load(8'hD0, 1, 1'b1);
    load(8'hD1, 2, 1'b0);
    wait_read("wm");
    fifo_usedw = 11'd2040;
    repeat (12) @(negedge clk);
    check("wm_pops", pops - p0, 32'd1);
    check("wm_state", {30'd0, dbg_state}, 32'd0);
    check("wm_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    check("wm_rxf_pending", {31'd0, ftdi_rxf_n}, 32'd0);
    check("wm_exp_empty", exp_q.size(), 32'd0);
    fifo_usedw = 11'd0;
    exp_q.push_back(8'hD1);
    exp_q.push_back(8'hD2);
    wait_drain("wm_resume");

    // tx_busy blocks a new burst only from IDLE
    tx_busy = 1'b1;
    load(8'hE0, 2, 1'b1);
    repeat (5) @(negedge clk);
    check("busy_state", {30'd0, dbg_state}, 32'd0);
    check("busy_pins", {30'd0, ftdi_oe_n, ftdi_rd_n}, 32'd3);
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy_drop_state", {30'd0, dbg_state}, 32'd1);
    check("busy_drop_oe_n", {31'd0, ftdi_oe_n}, 32'd0);
    tx_busy = 1'b1;
    wait_drain("busy_midburst");
    tx_busy = 1'b0;

    // asynchronous reset during the third byte of a burst
    load(8'hF0, 6, 1'b1);
    wait_read("rst");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pins", {29'd0, ftdi_oe_n, ftdi_rd_n, rx_active}, 32'd6);
    check("arst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("after_rst");
    check("after_rst_burst", burst_log[burst_log.size()-1], 32'd4);

`ifdef FTDI_RX_STAT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stat_rst_cnt", rx_byte_cnt, 32'd0);
    check("stat_rst_drop", {31'd0, rx_drop}, 32'd0);
    load(8'h50, 1, 1'b0);
    wait_read("stat");
    fifo_full = 1'b1;
    @(negedge clk);
    check("stat_drop_wrreq", {31'd0, fifo_wrreq}, 32'd0);
    check("stat_drop_flag", {31'd0, rx_drop}, 32'd1);
    fifo_full = 1'b0;
    wait_drain("stat_drop");
    load(8'h60, 5, 1'b1);
    wait_drain("stat_good");
    check("stat_byte_cnt", rx_byte_cnt, 32'd5);
    check("stat_drop_sticky", {31'd0, rx_drop}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftdi_to_fifo_wr_ctrl.md
Name: ftdi_to_fifo_wr_ctrl

Overview:
- Receive-direction counterpart of the FIFO-to-FTDI transmit path.
- Pulls bytes from the FTDI synchronous 245-style FIFO interface (RXF#/OE#/RD#) and writes them into the 2048-word RX FIFO.
- Provides watermark-based flow control, bus turnaround, and a burst limit so the TX path can get the shared bus.

Parameters:
- FIFO_DEPTH, 2048: RX FIFO depth in words; fifo_usedw is 11 bits.
- HEADROOM, 8: free words reserved to absorb pipeline skid; reading stops when usedw >= FIFO_DEPTH-HEADROOM.
- MAX_BURST, 512: maximum bytes per READ burst before the bus is released; range 1..2047.

Ports:
- clk  in  1  system clock, the FTDI 60 MHz CLKOUT domain.
- rst_n  in  1  asynchronous active-low reset.
- ftdi_rxf_n  in  1  low = FTDI has RX data.
- ftdi_data  in  8  FTDI data bus, input direction.
- ftdi_oe_n  out  1  FTDI output enable, active low.
- ftdi_rd_n  out  1  FTDI read strobe, active low.
- tx_busy  in  1  TX controller owns the bus; blocks a new RX burst.
- fifo_usedw  in  11  RX FIFO fill level.
- fifo_full  in  1  RX FIFO full.
- fifo_wrreq  out  1  RX FIFO write request.
- fifo_data  out  8  RX FIFO write data.
- rx_active  out  1  high while in OE, READ or RELEASE; TX side must not start while high.

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, ftdi_oe_n=1, ftdi_rd_n=1, fifo_wrreq=0, fifo_data=0, rx_active=0, burst_cnt=0.
- All outputs are registered.
- room = (fifo_usedw < FIFO_DEPTH-HEADROOM) && !fifo_full; computed combinationally from the current inputs.
- States (oe_n/rd_n/rx_active per state):
  - IDLE (1/1/0): go to OE when ftdi_rxf_n==0 && room && !tx_busy.
  - OE (0/1/1): one-cycle bus turnaround. If ftdi_rxf_n==1, go to RELEASE; else go to READ. burst_cnt=0.
  - READ (0/0/1): at each posedge with ftdi_rxf_n==0, capture ftdi_data and increment burst_cnt. Go to RELEASE at the edge where any of these holds:
    - ftdi_rxf_n==1;
    - !room;
    - the capture made burst_cnt==MAX_BURST.
  - RELEASE (1/1/1): one cycle, then go to IDLE. tx_busy is ignored here.
- Capture on the exit edge of READ is still valid when ftdi_rxf_n==0 at that edge; the byte is not lost.
- Write latency: the byte captured at edge N appears as fifo_data with fifo_wrreq=1 during cycle N+1. fifo_wrreq is high for exactly one cycle per captured byte.
- Back-to-back captures produce consecutive wrreq cycles, so throughput is 1 byte/clk.
- fifo_wrreq is gated by !fifo_full at the capture edge. A byte captured while fifo_full is dropped; HEADROOM>=2 makes this unreachable in normal operation.
- tx_busy is sampled only in IDLE; a mid-burst tx_busy assertion does not abort READ.
- rxf_n high on the edge leaving OE: no capture, go to RELEASE.
- MAX_BURST=1: OE, READ (one byte), RELEASE, IDLE.
- Reset asserted mid-burst: outputs are immediately inactive; bytes in flight are discarded.
- Minimum gap between bursts: IDLE, OE, READ is 2 cycles of overhead plus 1 RELEASE cycle.

Optional Feature:
- FTDI_RX_STAT_EN defined:
  - Adds output rx_byte_cnt[31:0]: increments on each fifo_wrreq, wraps at 2^32, reset to 0.
  - Adds output rx_drop (1 bit): set sticky when a capture is dropped due to fifo_full, cleared only by reset.
- Not defined: both ports are absent and there is no counter logic.

Test Plan:
- Reset then ftdi_rxf_n low with 4 bytes 0xA1..0xA4, usedw=0, tx_busy=0:
  - sequence IDLE, OE, READ×4, RELEASE, IDLE;
  - fifo_wrreq high for 4 consecutive cycles with data A1..A4, first write 1 cycle after the first capture;
  - ftdi_oe_n low 1 cycle before ftdi_rd_n.
- fifo_usedw=2039 (below 2040), continuous data: the first capture pushes usedw to 2040 and READ exits on that edge; total writes=1; no re-entry while usedw>=2040.
- MAX_BURST=4, 10 bytes pending:
  - bursts of 4, 4, 2 bytes;
  - each burst followed by a RELEASE cycle with oe_n=rd_n=1;
  - all 10 bytes written in order.
- tx_busy=1 with rxf_n low: stays IDLE, oe_n=rd_n=1. Drop tx_busy: OE is entered on the next edge.
- rst_n pulsed low during the 3rd byte of a burst: oe_n, rd_n go high and wrreq goes low asynchronously; after release, IDLE with burst_cnt=0.
- FTDI_RX_STAT_EN: force fifo_full=1 at a capture edge → no wrreq, rx_drop=1; then 5 good bytes → rx_byte_cnt=5.
